// File: rtl/mult8u_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult8u_pkg                                                                 |
// | Shared types and the Dadda height schedule for the 8x8 unsigned multiplier.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mult8u_pkg;

    localparam int N            = 8;
    localparam int ROW_W        = 2 * N - 2;
    localparam int c_num_levels = 4;
    localparam int c_dadda_heights [c_num_levels] = '{6, 4, 3, 2};

    typedef logic [ROW_W-1:0]          row_t;
    typedef logic [N-1:0][N-1:0]       pp_t;
    // Column k collects the bits of weight 2^(k+1); bit 0 is carried separately.
    typedef logic [ROW_W-1:0][N-1:0]   col_mat_t;

    function automatic int init_height(int k);
        int w = k + 1;
        return (w < N) ? w + 1 : 2 * N - 1 - w;
    endfunction

    function automatic int level_of(int h_out);
        int lvl = -1;
        for (int l = 0; l < c_num_levels; l++) begin
            if (c_dadda_heights[l] == h_out) lvl = l;
        end
        return lvl;
    endfunction

    // Column height entering level lvl.
    function automatic int col_height(int lvl, int k);
        int h [ROW_W];
        int cin;
        int ex;
        for (int c = 0; c < ROW_W; c++) h[c] = init_height(c);
        for (int l = 0; l < lvl; l++) begin
            cin = 0;
            for (int c = 0; c < ROW_W; c++) begin
                ex   = (h[c] + cin > c_dadda_heights[l]) ? h[c] + cin - c_dadda_heights[l] : 0;
                h[c] = h[c] + cin - ex;
                cin  = (ex + 1) / 2;
            end
        end
        return h[k];
    endfunction

    // Bits column k must shed at level lvl: 2 per full adder, 1 per half adder.
    function automatic int excess(int lvl, int k);
        int cin = 0;
        int ex  = 0;
        for (int c = 0; c <= k; c++) begin
            ex  = (col_height(lvl, c) + cin > c_dadda_heights[lvl])
                ? col_height(lvl, c) + cin - c_dadda_heights[lvl] : 0;
            cin = (ex + 1) / 2;
        end
        return ex;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult8u_dadda_level.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult8u_dadda_level                                                         |
// | One combinational Dadda reduction level down to height H_OUT.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mult8u_dadda_level
    import mult8u_pkg::*;
#(
    parameter int H_OUT = 6
) (
    input  logic [ROW_W-1:0][N-1:0] cols_in,
    output logic [ROW_W-1:0][N-1:0] cols_out
);

    localparam int c_lvl = level_of(H_OUT);
    localparam int c_lv  = (c_lvl < 0) ? 0 : c_lvl;

    logic [ROW_W-1:0][N-1:0] w_sum;
    logic [ROW_W-1:0][N-1:0] w_cry;
    logic                    w_unused;

    generate
        if (c_lvl < 0) begin : g_bad_height
            $error("mult8u_dadda_level: H_OUT is not in the Dadda schedule");
        end else if ((excess(c_lv, ROW_W - 1) + 1) / 2 != 0) begin : g_overflow
            $error("mult8u_dadda_level: carry escapes the top row column");
        end

        for (genvar k = 0; k < ROW_W; k++) begin : g_col
            localparam int c_h  = col_height(c_lv, k);
            localparam int c_ex = excess(c_lv, k);
            localparam int c_fa = c_ex / 2;
            localparam int c_ha = c_ex % 2;
            localparam int c_ns = c_fa + c_ha;
            localparam int c_np = c_h - 3 * c_fa - 2 * c_ha;
            localparam int c_ci = (excess(c_lv, k - 1) + 1) / 2;

            for (genvar i = 0; i < N; i++) begin : g_add
                if (i < c_fa) begin : g_fa
                    assign w_sum[k][i] = ^cols_in[k][3*i +: 3];
                    assign w_cry[k][i] = (cols_in[k][3*i]   & cols_in[k][3*i+1])
                                       | (cols_in[k][3*i]   & cols_in[k][3*i+2])
                                       | (cols_in[k][3*i+1] & cols_in[k][3*i+2]);
                end else if (i == c_fa && c_ha == 1) begin : g_ha
                    assign w_sum[k][i] = cols_in[k][3*c_fa] ^ cols_in[k][3*c_fa+1];
                    assign w_cry[k][i] = cols_in[k][3*c_fa] & cols_in[k][3*c_fa+1];
                end else begin : g_none
                    assign w_sum[k][i] = 1'b0;
                    assign w_cry[k][i] = 1'b0;
                end
            end

            // Output column: adder sums, untouched bits, then carries from column k-1.
            for (genvar j = 0; j < N; j++) begin : g_out
                if (j < c_ns) begin : g_sum
                    assign cols_out[k][j] = w_sum[k][j];
                end else if (j < c_ns + c_np) begin : g_pass
                    assign cols_out[k][j] = cols_in[k][3*c_fa + 2*c_ha + j - c_ns];
                end else if (j < c_ns + c_np + c_ci) begin : g_carry
                    assign cols_out[k][j] = w_cry[k-1][j - c_ns - c_np];
                end else begin : g_zero
                    assign cols_out[k][j] = 1'b0;
                end
            end
        end
    endgenerate

    assign w_unused = ^{cols_in, w_sum, w_cry};

endmodule
`default_nettype wire

// File: rtl/mult8u_ppg_dadda_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult8u_ppg_dadda_pipe                                                      |
// | 8x8 partial products + Dadda tree to two 14-bit rows, valid/ready pipe.    |
// | MULT8U_PPG_MIDREG_EN adds a register after the 8->6->4 levels (latency 2). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mult8u_ppg_dadda_pipe
    import mult8u_pkg::*;
#(
    parameter int N     = 8,
    parameter int ROW_W = 2 * N - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_lsb,
    output logic [ROW_W-1:0] out_row_a,
    output logic [ROW_W-1:0] out_row_b
);

    generate
        if (N != 8 || ROW_W != 2 * N - 2) begin : g_bad_cfg
            $error("mult8u_ppg_dadda_pipe supports only N=8 with ROW_W=2*N-2");
        end
    endgenerate

    pp_t      w_pp;
    col_mat_t w_cols0, w_cols1, w_cols2, w_cols3, w_cols4;
    col_mat_t w_mid_cols;
    logic     w_mid_valid, w_mid_lsb, w_lsb;
    logic     w_s2_adv;
    logic     w_unused;

    logic     r_s2_valid;
    logic     r_lsb;
    row_t     r_row_a, r_row_b;

    generate
        for (genvar i = 0; i < N; i++) begin : g_pp_row
            for (genvar j = 0; j < N; j++) begin : g_pp_bit
                assign w_pp[i][j] = in_a[j] & in_b[i];
            end
        end

        // Stack the products of weight k+1 at the bottom of column k.
        for (genvar k = 0; k < ROW_W; k++) begin : g_col0
            localparam int c_imin = (k + 2 > N) ? k + 2 - N : 0;
            for (genvar p = 0; p < N; p++) begin : g_bit
                if (p < init_height(k)) begin : g_pp
                    assign w_cols0[k][p] = w_pp[c_imin + p][k + 1 - c_imin - p];
                end else begin : g_zero
                    assign w_cols0[k][p] = 1'b0;
                end
            end
        end
    endgenerate

    assign w_lsb = w_pp[0][0];

    mult8u_dadda_level #(.H_OUT(c_dadda_heights[0])) u_lvl_a (.cols_in(w_cols0), .cols_out(w_cols1));
    mult8u_dadda_level #(.H_OUT(c_dadda_heights[1])) u_lvl_b (.cols_in(w_cols1), .cols_out(w_cols2));

    assign w_s2_adv = !r_s2_valid || out_ready;

`ifdef MULT8U_PPG_MIDREG_EN
    logic     r_s1_valid;
    logic     r_s1_lsb;
    col_mat_t r_s1_cols;
    logic     w_s1_adv;

    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_lsb   <= 1'b0;
            r_s1_cols  <= '0;
        end else begin
            if (flush)
                r_s1_valid <= 1'b0;
            else if (w_s1_adv)
                r_s1_valid <= in_valid;
            if (w_s1_adv && in_valid) begin
                r_s1_lsb  <= w_lsb;
                r_s1_cols <= w_cols2;
            end
        end
    end

    assign w_mid_valid = r_s1_valid;
    assign w_mid_lsb   = r_s1_lsb;
    assign w_mid_cols  = r_s1_cols;
`else
    assign in_ready    = w_s2_adv;
    assign w_mid_valid = in_valid;
    assign w_mid_lsb   = w_lsb;
    assign w_mid_cols  = w_cols2;
`endif

    mult8u_dadda_level #(.H_OUT(c_dadda_heights[2])) u_lvl_c (.cols_in(w_mid_cols), .cols_out(w_cols3));
    mult8u_dadda_level #(.H_OUT(c_dadda_heights[3])) u_lvl_d (.cols_in(w_cols3), .cols_out(w_cols4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_lsb      <= 1'b0;
            r_row_a    <= '0;
            r_row_b    <= '0;
        end else begin
            if (flush)
                r_s2_valid <= 1'b0;
            else if (w_s2_adv)
                r_s2_valid <= w_mid_valid;
            if (w_s2_adv && w_mid_valid) begin
                r_lsb <= w_mid_lsb;
                for (int k = 0; k < ROW_W; k++) begin
                    r_row_a[k] <= w_cols4[k][0];
                    r_row_b[k] <= w_cols4[k][1];
                end
            end
        end
    end

    assign w_unused  = ^w_cols4;
    assign out_valid = r_s2_valid;
    assign out_lsb   = r_lsb;
    assign out_row_a = r_row_a;
    assign out_row_b = r_row_b;

endmodule
`default_nettype wire

// File: tb/tb_mult8u_ppg_dadda_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mult8u_ppg_dadda_pipe                                                   |
// | Self-checking bench: vector table, handshake corners, scoreboard sweep.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mult8u_ppg_dadda_pipe;

`ifdef MULT8U_PPG_MIDREG_EN
    localparam int c_lat = 2;
`else
    localparam int c_lat = 1;
`endif
    localparam int c_sweep  = 8192;
    localparam int c_budget = 40000;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_lsb;
    logic [7:0]  in_a, in_b;
    logic [13:0] out_row_a, out_row_b;
    logic [14:0] w_cpa;
    logic [15:0] w_prod;

    int checks   = 0;
    int failures = 0;
    int n_deliv  = 0;
    logic [15:0] sb_q [$];

    always #5 clk = ~clk;

    mult8u_ppg_dadda_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lsb   (out_lsb),
        .out_row_a (out_row_a),
        .out_row_b (out_row_b)
    );

    // Downstream 14-bit CPA: {cout, sum, lsb} is the full product.
    assign w_cpa  = {1'b0, out_row_a} + {1'b0, out_row_b};
    assign w_prod = {w_cpa, out_lsb};

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
    endtask

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_deliv++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got product 0x%0h with no operation outstanding", w_prod);
                end else begin
                    chk("sb_product", int'(w_prod), int'(sb_q.pop_front()));
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(16'(in_a) * 16'(in_b));
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [12];
        logic [7:0]  bb_a [3];
        logic [7:0]  bb_b [3];
        logic [15:0] bb_p [3];
        logic [7:0]  bp_a [3];
        logic [7:0]  bp_b [3];
        int          base, sent, cyc, idx;
        logic        ok;

        vecs[0]  = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{8'h03, 8'h05, 16'h000F};
        vecs[2]  = '{8'h00, 8'hAB, 16'h0000};
        vecs[3]  = '{8'h80, 8'h80, 16'h4000};
        vecs[4]  = '{8'h07, 8'h09, 16'h003F};
        vecs[5]  = '{8'h01, 8'h01, 16'h0001};
        vecs[6]  = '{8'hFF, 8'h01, 16'h00FF};
        vecs[7]  = '{8'h01, 8'hFF, 16'h00FF};
        vecs[8]  = '{8'hAA, 8'h55, 16'h3872};
        vecs[9]  = '{8'hF0, 8'h0F, 16'h0E10};
        vecs[10] = '{8'h12, 8'h34, 16'h03A8};
        vecs[11] = '{8'h80, 8'hFF, 16'h7F80};
        bb_a = '{8'h03, 8'h00, 8'h80};
        bb_b = '{8'h05, 8'hAB, 8'h80};
        bb_p = '{16'd15, 16'd0, 16'h4000};
        bp_a = '{8'h11, 8'h33, 8'h55};
        bp_b = '{8'h22, 8'h44, 8'h66};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_lsb", out_lsb, 0);
        chk("reset_row_a", out_row_a, 0);
        chk("reset_row_b", out_row_b, 0);
        #6 rst_n = 1'b1;
        step();

        // Isolated operations: exact latency and final row values.
        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].a, vecs[v].b);
            #1;
            chk("vec_in_ready", in_ready, 1);
            step();
            in_valid = 1'b0;
            for (int c = 1; c <= c_lat; c++) begin
                #1;
                chk("vec_out_valid", out_valid, (c == c_lat) ? 1 : 0);
                if (c == c_lat) begin
                    chk("vec_lsb", out_lsb, vecs[v].p[0]);
                    chk("vec_row_sum", w_cpa, vecs[v].p[15:1]);
                end
                step();
            end
        end

        // Back-to-back stream at full throughput.
        for (int c = 0; c < 3 + c_lat + 1; c++) begin
            if (c < 3) drive(bb_a[c], bb_b[c]);
            else       in_valid = 1'b0;
            #1;
            if (c < 3) chk("b2b_in_ready", in_ready, 1);
            if (c >= c_lat && c < c_lat + 3) begin
                chk("b2b_out_valid", out_valid, 1);
                chk("b2b_lsb", out_lsb, bb_p[c - c_lat][0]);
                chk("b2b_row_sum", w_cpa, bb_p[c - c_lat][15:1]);
            end else begin
                chk("b2b_out_idle", out_valid, 0);
            end
            step();
        end

        // Backpressure: fill, hold stable, then drain.
        out_ready = 1'b0;
        base = n_deliv;
        for (int i = 0; i < c_lat; i++) begin
            drive(bp_a[i], bp_b[i]);
            #1;
            chk("bp_in_ready_accept", in_ready, 1);
            step();
        end
        drive(bp_a[c_lat], bp_b[c_lat]);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_in_ready_full", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold_lsb", out_lsb, 0);
            chk("bp_hold_rows", w_cpa, 16'h0242 >> 1);
            step();
        end
        out_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            #1;
            if (in_ready) ok = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("bp_last_accepted", ok, 1);
        for (int c = 0; c < 10 && n_deliv - base < c_lat + 1; c++) step();
        repeat (3) step();
        chk("bp_drain_count", n_deliv - base, c_lat + 1);

        // Flush with a full pipe and an operand offered.
        out_ready = 1'b0;
        drive(8'h02, 8'h03);
        step();
        if (c_lat > 1) begin
            drive(8'h04, 8'h05);
            step();
        end
        drive(8'h99, 8'h99);
        flush = 1'b1;
        #1;
        chk("flush_in_ready_full", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready_after", in_ready, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("flush_no_stale", out_valid, 0);
        end

        // Flush on an empty pipe drops the operand offered in the same cycle.
        drive(8'h21, 8'h21);
        flush = 1'b1;
        #1;
        chk("flush_in_ready_empty", in_ready, 1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < c_lat + 2; c++) begin
            #1;
            chk("flush_dropped", out_valid, 0);
            step();
        end
        drive(8'h07, 8'h09);
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= c_lat; c++) begin
            #1;
            chk("post_flush_valid", out_valid, (c == c_lat) ? 1 : 0);
            if (c == c_lat) begin
                chk("post_flush_lsb", out_lsb, 1);
                chk("post_flush_rows", w_cpa, 63 >> 1);
            end
            step();
        end

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        for (int i = 0; i < c_lat; i++) begin
            drive(8'hC3, 8'h3C);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("stall_out_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_lsb", out_lsb, 0);
        chk("arst_row_a", out_row_a, 0);
        chk("arst_row_b", out_row_b, 0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        step();
        drive(8'hC3, 8'h3C);
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= c_lat; c++) begin
            #1;
            chk("post_rst_valid", out_valid, (c == c_lat) ? 1 : 0);
            if (c == c_lat) chk("post_rst_rows", w_cpa, 16'h2DB4 >> 1);
            step();
        end

        // Operand sweep with random handshakes, checked by the scoreboard.
        base = n_deliv;
        sent = 0;
        cyc  = 0;
        while (sent < c_sweep && cyc < c_budget) begin
            idx       = sent * 8 + (sent % 8);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = idx[7:0];
            in_b      = idx[15:8];
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && n_deliv - base < sent; c++) step();
        chk("sweep_sent", sent, c_sweep);
        chk("sweep_delivered", n_deliv - base, c_sweep);
        chk("sweep_queue_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
